// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared debounce state encoding, defaults and index helper
// Contents:
//   db_state_e        per-key debounce FSM state encoding
//   TICK_DIV_DEFAULT  clock cycles per sample tick (100 Hz at 50 MHz)
//   wrap_add          (a + b) mod n, for operands already below n
package key_pkg;

    typedef enum logic [1:0] {
        DB_IDLE      = 2'd0,
        DB_PRESS_CHK = 2'd1,
        DB_HELD      = 2'd2,
        DB_REL_CHK   = 2'd3
    } db_state_e;

    localparam int TICK_DIV_DEFAULT = 500000;

    // Operands are both < n, so a single conditional subtract is enough.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/key_tick_gen.sv
// rtl/key_tick_gen.sv - shared debounce sample tick generator
// Ports:
//   Clk    in   system clock, rising edge
//   Rst_n  in   asynchronous active-low reset
//   Tick   out  high for one cycle when the counter reaches TICK_DIV-1
module key_tick_gen
    import key_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic Clk,
    input  logic Rst_n,
    output logic Tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign Tick  = (cnt_q == LAST);
    assign cnt_d = Tick ? '0 : cnt_q + CW'(1);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_event_scheduler.sv
// rtl/key_event_scheduler.sv - multi-key debouncer with round-robin press event queue
// Ports:
//   Clk        in   system clock, rising edge
//   Rst_n      in   asynchronous active-low reset
//   Key_xi     in   raw key levels, asynchronous, 1 = pressed
//   Key_level  out  debounced key levels
//   Ev_valid   out  an event is offered on Ev_code
//   Ev_ready   in   consumer accepts the event this cycle
//   Ev_code    out  index of the pressed key
//   Overrun    out  sticky: a press was lost
//   Ovr_clr    in   synchronous clear of Overrun
module key_event_scheduler
    import key_pkg::*;
#(
    parameter int  N_KEYS   = 4,
    parameter int  TICK_DIV = TICK_DIV_DEFAULT,
    localparam int IDW      = $clog2(N_KEYS)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [N_KEYS-1:0] Key_xi,
    output logic [N_KEYS-1:0] Key_level,
    output logic              Ev_valid,
    input  logic              Ev_ready,
    output logic [IDW-1:0]    Ev_code,
    output logic              Overrun,
    input  logic              Ovr_clr
);

    logic              tick;
    logic [N_KEYS-1:0] press_set;
    logic [N_KEYS-1:0] pend_q, pend_d;
    logic [N_KEYS-1:0] rot;
    logic [N_KEYS-1:0] gnt_vec;
    logic [IDW-1:0]    rr_q;
    logic [IDW-1:0]    gidx;
    logic [IDW-1:0]    ev_code_q;
    logic              ev_valid_q;
    logic              ovr_q;
    logic              slot_free;
    logic              grant_en;
    logic              ovr_set;
    int                off;

    key_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Tick  (tick)
    );

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic      s1_q, s2_q;
        logic      lvl_q;
        db_state_e st_q, st_d;

        always_comb begin
            st_d = st_q;
            if (tick) begin
                unique case (st_q)
                    DB_IDLE:      st_d = s2_q ? DB_PRESS_CHK : DB_IDLE;
                    DB_PRESS_CHK: st_d = s2_q ? DB_HELD      : DB_IDLE;
                    DB_HELD:      st_d = s2_q ? DB_HELD      : DB_REL_CHK;
                    DB_REL_CHK:   st_d = s2_q ? DB_HELD      : DB_IDLE;
                endcase
            end
        end

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                s1_q  <= 1'b0;
                s2_q  <= 1'b0;
                st_q  <= DB_IDLE;
                lvl_q <= 1'b0;
            end else begin
                s1_q  <= Key_xi[i];
                s2_q  <= s1_q;
                st_q  <= st_d;
                // Level follows the state it is entering, so both change on one edge.
                lvl_q <= (st_d == DB_HELD) || (st_d == DB_REL_CHK);
            end
        end

        assign press_set[i] = tick && (st_q == DB_PRESS_CHK) && s2_q;
        assign Key_level[i] = lvl_q;
    end

    // Rotate pending so bit 0 is the key just after the last grant, pick the
    // lowest set bit, then map the offset back to a key index.
    always_comb begin
        rot = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            rot[k] = pend_q[IDW'(wrap_add(int'(rr_q) + 1, k, N_KEYS))];
        end
    end

    always_comb begin
        off = 0;
        for (int k = N_KEYS - 1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
    end

    assign gidx      = IDW'(wrap_add(int'(rr_q) + 1, off, N_KEYS));
    assign slot_free = !ev_valid_q || Ev_ready;
    assign grant_en  = slot_free && (|pend_q);

    always_comb begin
        gnt_vec = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            gnt_vec[k] = grant_en && (gidx == IDW'(k));
        end
    end

    // A press landing on a bit that is granted this same edge is not a loss.
    assign ovr_set = |(press_set & pend_q & ~gnt_vec);
    assign pend_d  = (pend_q & ~gnt_vec) | press_set;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pend_q     <= '0;
            ovr_q      <= 1'b0;
            ev_valid_q <= 1'b0;
            ev_code_q  <= '0;
            rr_q       <= IDW'(N_KEYS - 1);
        end else begin
            pend_q <= pend_d;
            ovr_q  <= ovr_set | (ovr_q & ~Ovr_clr);
            if (slot_free) begin
                if (grant_en) begin
                    ev_valid_q <= 1'b1;
                    ev_code_q  <= gidx;
                    rr_q       <= gidx;
                end else begin
                    ev_valid_q <= 1'b0;
                end
            end
        end
    end

    assign Ev_valid = ev_valid_q;
    assign Ev_code  = ev_code_q;
    assign Overrun  = ovr_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// tb/tb_key_event_scheduler.sv - directed and randomized bench for key_event_scheduler
module tb_key_event_scheduler;

    localparam int N  = 4;
    localparam int TD = 4;

    logic         Clk      = 1'b0;
    logic         Rst_n    = 1'b0;
    logic [N-1:0] Key_xi   = '0;
    logic [N-1:0] Key_level;
    logic         Ev_valid;
    logic         Ev_ready = 1'b0;
    logic [1:0]   Ev_code;
    logic         Overrun;
    logic         Ovr_clr  = 1'b0;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    logic [N-1:0] key_cur = '0;

    // Reference state: debounced level is the value of the last two tick
    // samples whenever they agree; presses are the rising edges of that level.
    logic [N-1:0] m_lvl, m_prev, m_pend;
    logic         m_v, m_ovr;
    int           m_c, m_rr;
    int           accq[$];
    int           acct[$];

    key_event_scheduler #(.N_KEYS(N), .TICK_DIV(TD)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Key_xi    (Key_xi),
        .Key_level (Key_level),
        .Ev_valid  (Ev_valid),
        .Ev_ready  (Ev_ready),
        .Ev_code   (Ev_code),
        .Overrun   (Overrun),
        .Ovr_clr   (Ovr_clr)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int i);
        return (accq.size() > i) ? accq[i] : -1;
    endfunction

    function automatic int tget(input int i);
        return (acct.size() > i) ? acct[i] : -100;
    endfunction

    task automatic model_reset();
        m_lvl  = '0;
        m_prev = '0;
        m_pend = '0;
        m_v    = 1'b0;
        m_c    = 0;
        m_rr   = N - 1;
        m_ovr  = 1'b0;
        ecnt   = 0;
    endtask

    task automatic model_edge(input logic rdy, input logic clr, input logic tck);
        logic         free;
        logic         nl;
        logic         set_o;
        logic [N-1:0] press;
        int           g;
        free = !m_v || rdy;
        g = -1;
        if (free) begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
        end
        press = '0;
        if (tck) begin
            for (int i = 0; i < N; i++) begin
                nl = (m_prev[i] == key_cur[i]) ? key_cur[i] : m_lvl[i];
                press[i]  = nl & ~m_lvl[i];
                m_lvl[i]  = nl;
                m_prev[i] = key_cur[i];
            end
        end
        set_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (press[i] && m_pend[i] && g != i) set_o = 1'b1;
        end
        if (g >= 0) begin
            m_pend[g] = 1'b0;
            m_v  = 1'b1;
            m_c  = g;
            m_rr = g;
        end else if (free) begin
            m_v = 1'b0;
        end
        m_pend = m_pend | press;
        m_ovr  = set_o | (m_ovr & !clr);
    endtask

    task automatic step();
        logic tck;
        if (Ev_valid === 1'b1 && Ev_ready) begin
            accq.push_back(int'(Ev_code));
            acct.push_back(ecnt);
        end
        tck = ((ecnt % TD) == TD - 1);
        @(posedge Clk);
        model_edge(Ev_ready, Ovr_clr, tck);
        ecnt++;
        #1;
        chk("key_level", Key_level, m_lvl);
        chk("ev_valid", Ev_valid, m_v);
        chk("overrun", Overrun, m_ovr);
        if (m_v) chk("ev_code", Ev_code, m_c[1:0]);
    endtask

    // One tick period with keys changed just after the previous tick edge.
    // rmode: 0 ready low, 1 ready high, 2 random ready and occasional clear.
    task automatic period(input logic [N-1:0] keys, input int rmode);
        key_cur = keys;
        Key_xi  = keys;
        for (int c = 0; c < TD; c++) begin
            if (rmode == 2) begin
                Ev_ready = ($urandom_range(0, 3) != 0);
                Ovr_clr  = ($urandom_range(0, 15) == 0);
            end else begin
                Ev_ready = (rmode == 1);
                Ovr_clr  = 1'b0;
            end
            step();
        end
    endtask

    task automatic hard_reset();
        Rst_n    = 1'b0;
        Ev_ready = 1'b0;
        Ovr_clr  = 1'b0;
        Key_xi   = key_cur;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_level", Key_level, 0);
        chk("rst_valid", Ev_valid, 0);
        chk("rst_code", Ev_code, 0);
        chk("rst_overrun", Overrun, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        model_reset();
        accq.delete();
        acct.delete();
    endtask

    initial begin
        logic [N-1:0] nk;

        // 1: single press held three ticks
        key_cur = '0;
        hard_reset();
        period(4'b0100, 1);
        chk("s1_level_t1", Key_level, 4'b0000);
        period(4'b0100, 1);
        chk("s1_level_t2", Key_level, 4'b0100);
        period(4'b0100, 1);
        period(4'b0000, 1);
        period(4'b0000, 1);
        chk("s1_events", accq.size(), 1);
        chk("s1_code", qget(0), 2);

        // 2: one-tick glitch
        accq.delete();
        period(4'b0010, 1);
        repeat (3) period(4'b0000, 1);
        chk("s2_events", accq.size(), 0);
        chk("s2_level", Key_level, 4'b0000);

        // 3: simultaneous presses, then a later press served in rr order
        key_cur = '0;
        hard_reset();
        repeat (2) period(4'b1011, 1);
        repeat (2) period(4'b0000, 1);
        repeat (2) period(4'b0101, 1);
        period(4'b0000, 1);
        chk("s3_events", accq.size(), 5);
        chk("s3_code0", qget(0), 0);
        chk("s3_code1", qget(1), 1);
        chk("s3_code2", qget(2), 3);
        chk("s3_b2b_a", tget(1) - tget(0), 1);
        chk("s3_b2b_b", tget(2) - tget(1), 1);
        chk("s3_code3", qget(3), 0);
        chk("s3_code4", qget(4), 2);

        // 4: consumer stalled across repeated presses of key 2
        key_cur = '0;
        hard_reset();
        repeat (2) period(4'b0100, 0);
        repeat (2) period(4'b0000, 0);
        repeat (2) period(4'b0100, 0);
        chk("s4_ovr_second", Overrun, 0);
        chk("s4_hold_valid", Ev_valid, 1);
        chk("s4_hold_code", Ev_code, 2);
        repeat (2) period(4'b0000, 0);
        repeat (2) period(4'b0100, 0);
        chk("s4_ovr_third", Overrun, 1);
        period(4'b0000, 1);
        chk("s4_events", accq.size(), 2);
        chk("s4_code0", qget(0), 2);
        chk("s4_code1", qget(1), 2);
        Ovr_clr = 1'b1;
        step();
        Ovr_clr = 1'b0;
        chk("s4_ovr_clr", Overrun, 0);
        repeat (3) step();

        // 5: asynchronous reset with an event offered and another pending
        key_cur = '0;
        hard_reset();
        repeat (2) period(4'b0011, 0);
        step();
        chk("s5_pre_valid", Ev_valid, 1);
        #3;
        Rst_n = 1'b0;
        #1;
        chk("s5_async_level", Key_level, 0);
        chk("s5_async_valid", Ev_valid, 0);
        chk("s5_async_code", Ev_code, 0);
        chk("s5_async_ovr", Overrun, 0);
        key_cur = 4'b1000;
        hard_reset();
        repeat (8) step();
        chk("s5_wait", Ev_valid, 0);
        step();
        chk("s5_post_valid", Ev_valid, 1);
        chk("s5_post_code", Ev_code, 3);
        repeat (3) step();

        // Randomized key activity and consumer back-pressure
        key_cur = '0;
        hard_reset();
        for (int p = 0; p < 80; p++) begin
            nk = key_cur;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) == 0) nk[i] = ~nk[i];
            end
            period(nk, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
